// File: rtl/pc_sequencer.sv
// Program-counter owner with IDLE/RUN/DONE control and a saturating retire counter.
// Define PC_RAS_EN to add call/ret ports, a circular return-address stack and ras_err.
module pc_sequencer #(
    parameter int D         = 12,
    parameter int CNT_W     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [D-1:0]     start_address,
    input  logic             branch,
    input  logic             taken,
    input  logic [D-1:0]     target,
    input  logic             halt,
    input  logic             stall,
`ifdef PC_RAS_EN
    input  logic             call,
    input  logic             ret,
`endif
    output logic [D-1:0]     prog_ctr,
    output logic             fetch_valid,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
`ifdef PC_RAS_EN
    ,
    output logic             ras_err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic        [D-1:0]     pc, pc_nxt;
    logic        [CNT_W-1:0] cnt, cnt_nxt;
    logic signed [D-1:0]     offset;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign offset = target;

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [D-1:0] stack [RAS_DEPTH];
    logic [PW-1:0] sp;
    logic [PW:0]   depth;
    logic          err;
    logic          push, pop, clear;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] wrap_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(RAS_DEPTH - 1) : p - PW'(1);
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
`ifdef PC_RAS_EN
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
`endif
        // start overrides everything, in any state
        if (start) begin
            state_nxt = RUN;
            pc_nxt    = start_address;
            cnt_nxt   = '0;
`ifdef PC_RAS_EN
            clear     = 1'b1;
`endif
        end else if (state == RUN && !stall) begin
            cnt_nxt = sat_inc(cnt);
            if (halt) begin
                state_nxt = DONE;
`ifdef PC_RAS_EN
            end else if (ret) begin
                pop = 1'b1;
                if (depth == '0) pc_nxt = pc + D'(1);
                else             pc_nxt = stack[wrap_dec(sp)];
            end else if (call) begin
                push   = 1'b1;
                pc_nxt = pc + offset;
`endif
            end else if (branch && taken) begin
                pc_nxt = pc + offset;
            end else begin
                pc_nxt = pc + D'(1);
            end
        end
    end

`ifdef PC_RAS_EN
    // a push onto a full stack overwrites the oldest slot, keeping the newest RAS_DEPTH returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else if (clear) begin
            sp    <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else if (push) begin
            sp <= wrap_inc(sp);
            if (depth == (PW+1)'(RAS_DEPTH)) err   <= 1'b1;
            else                             depth <= depth + (PW+1)'(1);
        end else if (pop) begin
            if (depth == '0) begin
                err <= 1'b1;
            end else begin
                sp    <= wrap_dec(sp);
                depth <= depth - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack[sp] <= pc + D'(1);
    end

    assign ras_err = err;
`endif

    assign prog_ctr    = pc;
    assign fetch_valid = (state == RUN);
    assign done        = (state == DONE);
    assign instr_count = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus random bench for pc_sequencer against a queue-based reference model.
// Return-stack checks are compiled in when PC_RAS_EN is defined.
module tb_pc_sequencer;
    localparam int D = 12;
    localparam int CNT_W = 4;
    localparam int RAS_DEPTH = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic start, branch, taken, halt, stall, call, ret;
    logic [D-1:0] start_address, target;
    logic [D-1:0] prog_ctr;
    logic fetch_valid, done;
    logic [CNT_W-1:0] instr_count;
    logic ras_err;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    int m_pc, m_cnt;
    bit m_run, m_done, m_err;
    int m_stk[$];

    always #5 clk = ~clk;

    pc_sequencer #(.D(D), .CNT_W(CNT_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_address(start_address),
        .branch(branch), .taken(taken), .target(target), .halt(halt), .stall(stall),
`ifdef PC_RAS_EN
        .call(call), .ret(ret),
`endif
        .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .done(done),
        .instr_count(instr_count)
`ifdef PC_RAS_EN
        , .ras_err(ras_err)
`endif
    );

`ifndef PC_RAS_EN
    assign ras_err = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".prog_ctr"}, 32'(prog_ctr), 32'(m_pc));
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(m_run));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".instr_count"}, 32'(instr_count), 32'(m_cnt));
`ifdef PC_RAS_EN
        chk({tag, ".ras_err"}, 32'(ras_err), 32'(m_err));
`endif
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_err = 0;
        m_stk.delete();
    endtask

    task automatic step(input string tag, input logic st, input logic [D-1:0] sa,
                        input logic br, input logic tk, input logic [D-1:0] tg,
                        input logic h, input logic sl, input logic cl, input logic rt);
        @(negedge clk);
        start = st; start_address = sa; branch = br; taken = tk; target = tg;
        halt = h; stall = sl; call = cl; ret = rt;
        @(posedge clk);
        #1;
        if (st) begin
            m_run = 1; m_done = 0; m_pc = sa; m_cnt = 0; m_err = 0;
            m_stk.delete();
        end else if (m_run && !sl) begin
            m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            if (h) begin
                m_run = 0; m_done = 1;
`ifdef PC_RAS_EN
            end else if (rt) begin
                if (m_stk.size() == 0) begin
                    m_err = 1; m_pc = (m_pc + 1) % (1 << D);
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (cl) begin
                if (m_stk.size() == RAS_DEPTH) begin
                    void'(m_stk.pop_front()); m_err = 1;
                end
                m_stk.push_back((m_pc + 1) % (1 << D));
                m_pc = (m_pc + int'(tg)) % (1 << D);
`endif
            end else if (br && tk) begin
                m_pc = (m_pc + int'(tg)) % (1 << D);
            end else begin
                m_pc = (m_pc + 1) % (1 << D);
            end
        end
        start = 0; halt = 0; branch = 0; taken = 0; stall = 0; call = 0; ret = 0;
        check_all(tag);
    endtask

    task automatic plain(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        start = 0; start_address = 0; branch = 0; taken = 0; target = 0;
        halt = 0; stall = 0; call = 0; ret = 0;
        rst_n = 0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        step("start010", 1, 12'h010, 0, 0, 0, 0, 0, 0, 0);
        plain("inc011");
        plain("inc012");

        step("start020", 1, 12'h020, 0, 0, 0, 0, 0, 0, 0);
        step("br_taken", 0, 0, 1, 1, 12'hFFC, 0, 0, 0, 0);
        chk("br_taken_abs", 32'(prog_ctr), 32'h01C);
        step("start020b", 1, 12'h020, 0, 0, 0, 0, 0, 0, 0);
        step("br_not_taken", 0, 0, 1, 0, 12'hFFC, 0, 0, 0, 0);
        chk("br_not_taken_abs", 32'(prog_ctr), 32'h021);
        step("startFFF", 1, 12'hFFF, 0, 0, 0, 0, 0, 0, 0);
        plain("wrap");
        chk("wrap_abs", 32'(prog_ctr), 32'h000);
        step("start002", 1, 12'h002, 0, 0, 0, 0, 0, 0, 0);
        step("br_wrap", 0, 0, 1, 1, 12'hFFE, 0, 0, 0, 0);

        step("start030", 1, 12'h030, 0, 0, 0, 0, 0, 0, 0);
        step("halt", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("halt_done_abs", 32'(done), 32'h1);
        for (int i = 0; i < 10; i++) step("done_hold", 0, 0, 1, 1, 12'h005, 1, 0, 0, 0);
        step("restart100", 1, 12'h100, 0, 0, 0, 0, 0, 0, 0);

        step("start050", 1, 12'h050, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 1, 1, 12'h005, 0, 1, 0, 0);
        step("start_halt", 1, 12'h0A0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) plain("saturate");

        // asynchronous reset between clock edges
        #2 rst_n = 0;
        #1 model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1;
        plain("idle_after_reset");

`ifdef PC_RAS_EN
        step("start040", 1, 12'h040, 0, 0, 0, 0, 0, 0, 0);
        step("call", 0, 0, 0, 0, 12'h010, 0, 0, 1, 0);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("nest_call", 0, 0, 0, 0, 12'h020, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step("unwind", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("start_clr", 1, 12'h200, 0, 0, 0, 0, 0, 0, 0);
        step("ret_empty", 0, 0, 0, 0, 0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic st, br, tk, h, sl, cl, rt;
            logic [D-1:0] sa, tg;
            st = ($urandom_range(0, 24) == 0);
            sa = D'($urandom);
            br = $urandom_range(0, 1);
            tk = $urandom_range(0, 1);
            tg = ($urandom_range(0, 1) == 1) ? D'($urandom) : D'($urandom_range(0, 6) - 3);
            h  = ($urandom_range(0, 39) == 0);
            sl = ($urandom_range(0, 3) == 0);
`ifdef PC_RAS_EN
            cl = ($urandom_range(0, 5) == 0);
            rt = ($urandom_range(0, 5) == 0);
`else
            cl = 0;
            rt = 0;
`endif
            step("random", st, sa, br, tk, tg, h, sl, cl, rt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Sequential program-counter owner for the single-cycle core. It holds the architectural PC register and drives the fetch address. It applies the next-PC rule (start load, taken-branch relative jump, or increment) and runs a run/halt state machine that reports program completion. It is the consumer of the next-PC value and the producer of the current PC fed back to the next-PC logic and instruction memory.

## Interface
- D, 12, PC / address width in bits
- CNT_W, 16, width of retired-instruction counter
- RAS_DEPTH, 4, return-address stack entries (used only with PC_RAS_EN)

- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse: load start_address and begin running
- start_address  input  D  program entry point
- branch  input  1  current instruction is a branch
- taken  input  1  branch condition true
- target  input  D  signed two's-complement PC-relative offset
- halt  input  1  current instruction is the halt/done opcode
- stall  input  1  freeze PC and counter this cycle
- call  input  1  (PC_RAS_EN only) current instruction is a relative call
- ret  input  1  (PC_RAS_EN only) current instruction is a return
- prog_ctr  output  D  current PC / fetch address
- fetch_valid  output  1  prog_ctr addresses a live instruction (state RUN)
- done  output  1  program finished, held until next start
- instr_count  output  CNT_W  instructions retired since last start
- ras_err  output  1  (PC_RAS_EN only) sticky stack under/overflow flag

## Operation
- States: IDLE, RUN, DONE. fetch_valid = (state==RUN); done = (state==DONE).
- IDLE: PC holds. start -> PC=start_address, instr_count=0, state RUN.
- RUN, start=1: restart; same as IDLE start (start has highest priority in every state).
- RUN, stall=1: PC, counter, stack unchanged; halt/branch/call/ret ignored.
- RUN, stall=0, priority halt > ret > call > branch:
  - halt: state DONE, PC holds, instr_count+1.
  - branch&&taken: PC = PC+target. Otherwise PC = PC+1. instr_count+1.
- DONE: PC and instr_count hold; only start leaves (-> RUN as above).
- Arithmetic: PC modulo 2^D; PC+target wraps (e.g., D=12: 0xFFF+1=0x000, 0x002+0xFFE=0x000). instr_count saturates at all-ones.
- branch without taken = plain increment.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): state IDLE, prog_ctr=0, instr_count=0, fetch_valid=0, done=0, ras_err=0, stack empty.
- Reset mid-RUN: outputs return to reset values immediately, independent of clk.
- All outputs registered or decoded from registered state; one-cycle latency from inputs to prog_ctr.
- start sampled on edge N -> prog_ctr=start_address, fetch_valid=1 after edge N.
- halt sampled on edge N -> done=1 after edge N, stays 1 through any number of cycles until start.
- start and halt in same cycle: start wins, state RUN, done stays 0.

## Configuration
- PC_RAS_EN defined: call/ret/ras_err ports and RAS_DEPTH-entry return-address stack present.
  - call (RUN, no stall, no halt/ret): push PC+1, PC = PC+target.
  - ret: pop top -> PC.
  - push when full: oldest entry dropped (circular), ras_err=1.
  - pop when empty: PC = PC+1, ras_err=1.
  - ras_err sticky; cleared by start or reset. start also empties stack.
- PC_RAS_EN undefined: no stack, ports call/ret/ras_err absent, behaviour exactly as in Operation.

## Test plan
- Reset then start with start_address=0x010 -> prog_ctr 0x010, 0x011, 0x012 on successive edges, fetch_valid=1, instr_count counts 0,1,2.
- At PC 0x020, branch=taken=1, target=0xFFC -> next prog_ctr 0x01C; taken=0 -> 0x021; PC 0xFFF, no branch -> 0x000.
- halt at PC 0x030 -> done=1, prog_ctr stays 0x030 for 10 cycles; start with 0x100 -> prog_ctr 0x100, done=0, instr_count 0.
- stall=1 for 3 cycles with branch=taken=1 -> prog_ctr and instr_count unchanged; start+halt same cycle -> RUN at start_address.
- rst_n low mid-RUN between edges -> prog_ctr=0, state IDLE, done=0 immediately.
- PC_RAS_EN: call at 0x040 target 0x010 -> PC 0x050, ret -> 0x041; 5 nested calls with depth 4 -> ras_err=1; ret on empty stack -> PC+1, ras_err=1.
